// File: rtl/serial_paralelo_rx_sync.sv
// Serial-to-parallel receiver for the bit-clock domain.
// Finds the comma boundary, tracks lock and drops it on repeated slips.
module serial_paralelo_rx_sync #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
  parameter int              LOCK_COUNT = 4,
  parameter int              SLIP_LIMIT = 3
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] sp_out,
  output logic             word_stb,
  output logic             valid_out_sp,
  output logic             active,
  output logic             sync_lost
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(SLIP_LIMIT + 1);

  localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);
  localparam logic [SW-1:0] SLIP_N = SW'(SLIP_LIMIT);

  typedef enum logic [1:0] {
    SEARCH,
    SYNC,
    ACTIVE
  } state_t;

  state_t          state;
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   comma_cnt;
  logic [SW-1:0]   slip_cnt;

  logic [WIDTH-1:0] sr_next;
  logic             hit;
  logic             boundary;
  logic [CW-1:0]    comma_nx;
  logic [SW-1:0]    slip_nx;

  always_comb begin
    sr_next  = {sr, data_in};
    hit      = (sr_next == COMMA);
    boundary = (state != SEARCH) &&
               (bit_cnt == LAST);
    comma_nx = (comma_cnt == LOCK_N) ?
               comma_cnt :
               comma_cnt + CW'(1);
    slip_nx  = (slip_cnt == SLIP_N) ?
               slip_cnt :
               slip_cnt + SW'(1);
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state        <= SEARCH;
      sr           <= '0;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      slip_cnt     <= '0;
      sp_out       <= '0;
      word_stb     <= 1'b0;
      valid_out_sp <= 1'b0;
      active       <= 1'b0;
      sync_lost    <= 1'b0;
    end else begin
      sr           <= sr_next[WIDTH-2:0];
      word_stb     <= 1'b0;
      valid_out_sp <= 1'b0;
      sync_lost    <= 1'b0;
      bit_cnt      <= (bit_cnt == LAST) ?
                      '0 : bit_cnt + BW'(1);
      unique case (state)
        SEARCH: begin
          if (hit) begin
            bit_cnt   <= '0;
            comma_cnt <= CW'(1);
            slip_cnt  <= '0;
            sp_out    <= COMMA;
            word_stb  <= 1'b1;
            state     <= (LOCK_COUNT == 1) ?
                         ACTIVE : SYNC;
            active    <= (LOCK_COUNT == 1);
          end
        end
        SYNC, ACTIVE: begin
          if (boundary) begin
            sp_out       <= sr_next;
            word_stb     <= 1'b1;
            valid_out_sp <= (state == ACTIVE) && !hit;
            if (state == SYNC) begin
              if (hit) begin
                comma_cnt <= comma_nx;
                if (comma_nx == LOCK_N) begin
                  state  <= ACTIVE;
                  active <= 1'b1;
                end
              end else begin
                state     <= SEARCH;
                active    <= 1'b0;
                sync_lost <= 1'b1;
                comma_cnt <= '0;
                slip_cnt  <= '0;
              end
            end else if (hit) begin
              slip_cnt <= '0;
            end
          end else if (hit) begin
            // comma seen off the word boundary
            slip_cnt <= slip_nx;
            if (slip_nx == SLIP_N) begin
              state     <= SEARCH;
              active    <= 1'b0;
              sync_lost <= 1'b1;
              comma_cnt <= '0;
              slip_cnt  <= '0;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx_sync.sv
// Directed bench for serial_paralelo_rx_sync.
// Two instances: default 8-bit and a 10-bit, LOCK_COUNT=2 variant.
module tb_serial_paralelo_rx_sync;

  logic clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic       r1, d1, r2, d2;
  logic [7:0] sp1;
  logic       ws1, vo1, ac1, sl1;
  logic [9:0] sp2;
  logic       ws2, vo2, ac2, sl2;

  int n_cmp = 0;
  int n_bad = 0;

  serial_paralelo_rx_sync u_dut8 (
    .clk_32f      (clk_32f),
    .reset_L      (r1),
    .data_in      (d1),
    .sp_out       (sp1),
    .word_stb     (ws1),
    .valid_out_sp (vo1),
    .active       (ac1),
    .sync_lost    (sl1)
  );

  serial_paralelo_rx_sync #(
    .WIDTH      (10),
    .COMMA      (10'h17C),
    .LOCK_COUNT (2),
    .SLIP_LIMIT (3)
  ) u_dut10 (
    .clk_32f      (clk_32f),
    .reset_L      (r2),
    .data_in      (d2),
    .sp_out       (sp2),
    .word_stb     (ws2),
    .valid_out_sp (vo2),
    .active       (ac2),
    .sync_lost    (sl2)
  );

  typedef struct {
    int         seg;
    int         sel;
    logic [9:0] word;
    logic       stb;
    logic       vld;
    logic       act;
    logic       lost;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int         seg,
    input int         sel,
    input logic [9:0] w,
    input logic       s,
    input logic       v,
    input logic       a,
    input logic       l
  );
    vec_t r;
    r.seg  = seg;
    r.sel  = sel;
    r.word = w;
    r.stb  = s;
    r.vld  = v;
    r.act  = a;
    r.lost = l;
    return r;
  endfunction

  task automatic chk(
    input string      nm,
    input logic [9:0] got,
    input logic [9:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) d1 = b;
    else          d2 = b;
    @(negedge clk_32f);
  endtask

  task automatic sample(
    input  int         sel,
    output logic [9:0] sp,
    output logic       s,
    output logic       v,
    output logic       a,
    output logic       l
  );
    if (sel == 0) begin
      sp = {2'b00, sp1};
      s = ws1; v = vo1; a = ac1; l = sl1;
    end else begin
      sp = sp2;
      s = ws2; v = vo2; a = ac2; l = sl2;
    end
  endtask

  task automatic quiet(input int sel, input string nm);
    logic [9:0] sp;
    logic s, v, a, l;
    sample(sel, sp, s, v, a, l);
    chk({nm, " stb/vld/lost"}, {7'b0, s, v, l}, 10'h0);
  endtask

  task automatic run_seg(input int seg);
    logic [9:0] sp;
    logic s, v, a, l;
    int n;
    foreach (tbl[i]) begin
      if (tbl[i].seg == seg) begin
        n = (tbl[i].sel == 0) ? 8 : 10;
        for (int b = n - 1; b >= 0; b--) begin
          drive_bit(tbl[i].sel, tbl[i].word[b]);
          if (b > 0)
            quiet(tbl[i].sel, $sformatf("v%0d bit%0d", i, b));
        end
        sample(tbl[i].sel, sp, s, v, a, l);
        chk($sformatf("v%0d stb", i), {9'b0, s}, {9'b0, tbl[i].stb});
        chk($sformatf("v%0d vld", i), {9'b0, v}, {9'b0, tbl[i].vld});
        chk($sformatf("v%0d act", i), {9'b0, a}, {9'b0, tbl[i].act});
        chk($sformatf("v%0d lost", i), {9'b0, l}, {9'b0, tbl[i].lost});
        if (tbl[i].stb)
          chk($sformatf("v%0d sp", i), sp, tbl[i].word);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bc;
    logic [9:0] sp;
    logic s, v, a, l;
    bc = 8'hBC;

    // 8-bit: initial alignment, data, reset-release tail
    tbl.push_back(mk(0, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 10'h0BC, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h055, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h0A3, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 10'h0BC, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 10'h00F, 1, 1, 1, 0));
    // SYNC break then re-lock
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10'h012, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10'h0BC, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 10'h077, 1, 1, 1, 0));
    // re-lock after slip at the new offset
    tbl.push_back(mk(2, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(2, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(2, 0, 10'h0BC, 1, 0, 0, 0));
    tbl.push_back(mk(2, 0, 10'h0BC, 1, 0, 1, 0));
    tbl.push_back(mk(2, 0, 10'h0A5, 1, 1, 1, 0));
    // 10-bit instance
    tbl.push_back(mk(3, 1, 10'h17C, 1, 0, 0, 0));
    tbl.push_back(mk(3, 1, 10'h17C, 1, 0, 1, 0));
    tbl.push_back(mk(3, 1, 10'h155, 1, 1, 1, 0));
    tbl.push_back(mk(3, 1, 10'h17C, 1, 0, 1, 0));
    tbl.push_back(mk(3, 1, 10'h2A3, 1, 1, 1, 0));

    r1 = 1'b0; r2 = 1'b0; d1 = 1'b0; d2 = 1'b0;
    repeat (3) @(negedge clk_32f);
    sample(0, sp, s, v, a, l);
    chk("rst8 sp", sp, 10'h0);
    chk("rst8 flags", {6'b0, s, v, a, l}, 10'h0);
    sample(1, sp, s, v, a, l);
    chk("rst10 sp", sp, 10'h0);
    chk("rst10 flags", {6'b0, s, v, a, l}, 10'h0);

    r1 = 1'b1; r2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_bit(0, 1'($urandom_range(0, 1)));
      quiet(0, $sformatf("pre bit%0d", i));
    end
    run_seg(0);

    // partial comma, then async reset between edges
    for (int i = 7; i >= 1; i--) begin
      drive_bit(0, bc[i]);
      quiet(0, $sformatf("part bit%0d", i));
    end
    sample(0, sp, s, v, a, l);
    chk("pre-rst act", {9'b0, a}, 10'h1);
    #2;
    r1 = 1'b0;
    #1;
    sample(0, sp, s, v, a, l);
    chk("async sp", sp, 10'h0);
    chk("async flags", {6'b0, s, v, a, l}, 10'h0);
    @(negedge clk_32f);
    r1 = 1'b1;
    drive_bit(0, 1'b0);
    quiet(0, "sr cleared");

    run_seg(1);

    // one extra bit, then continuous commas
    drive_bit(0, 1'b0);
    quiet(0, "slip extra");
    for (int k = 1; k <= 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        drive_bit(0, bc[i]);
        sample(0, sp, s, v, a, l);
        if (i == 1) begin
          chk($sformatf("slip%0d sp", k), sp, 10'h05E);
          chk($sformatf("slip%0d bnd", k),
              {6'b0, s, v, a, l}, 10'b1110);
        end else if (i == 0) begin
          chk($sformatf("slip%0d mis", k),
              {6'b0, s, v, a, l},
              (k == 3) ? 10'b0001 : 10'b0010);
        end else begin
          quiet(0, $sformatf("slip%0d bit%0d", k, i));
        end
      end
    end

    run_seg(2);
    run_seg(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
